lsu_mc: RTL
===========

# lsu_mc

Multi-cycle, handshaked load/store unit for the single-cycle-to-pipelined core transition. It replaces the combinational LSU with a request/response port, a parametrised synchronous-read data memory, and a parametrised memory-mapped IO block. Misaligned accesses are either split into two word accesses or trapped, selected by parameter. It sits between the core's memory stage and the DMEM/PIO resources.

## Interface

Parameters:
- DMEM_WORDS, 512: data memory depth in 32-bit words (power of two); DMEM spans bytes 0 to DMEM_WORDS*4-1.
- N_HEX, 8: number of 7-segment digits; N_HEX is 8 or less.
- MISALIGN_TRAP, 0: 0 = split misaligned access into two word accesses; 1 = reject with error.

Ports:
- i_clk  in  1  clock; reset i_reset, asynchronous, active-high; clock i_clk.
- i_reset  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid and ready are both high at a rising edge.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- i_req_wren  in  1  1 store, 0 load.
- i_req_signed  in  1  sign-extend load result.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load data (0 for stores/errors).
- o_rsp_err  out  1  access fault or trapped misalignment, valid with o_rsp_valid.
- o_io_ledr  out  32; o_io_ledg  out  32; o_io_lcd  out  32  output registers.
- o_io_hex  out  N_HEX*7  digit i at bits [7i+6:7i].
- i_io_sw  in  32  switches, asynchronous to the core.

## Operation

- FSM states: IDLE, ACC0, ACC1, RESP. o_req_ready = (state == IDLE).
- IDLE: on handshake, latch addr/wdata/size/wren/signed and go to ACC0.
- ACC0: access word addr[31:2] (DMEM) or IO register. If split is required, go to ACC1; otherwise go to RESP.
- ACC1: access word addr[31:2]+1 for the upper bytes, then go to RESP.
- RESP: assert o_rsp_valid, o_rsp_rdata and o_rsp_err for one cycle, then go to IDLE. No backpressure.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
  - A half at offset 01 is not split: one access, mask 0110.
  - Split cases: word at offsets 01, 10, 11 and half at offset 11.
- Byte masks for the first word: byte = 0001 << off; half = 0011 << off. A split access writes the remainder in the second word starting at byte 0.
- Store data is shifted left by 8*off. Overflow bytes go to the second word, low byte first.
- Load data is the concatenation {word1, word0} shifted right by 8*off and truncated to size. It is zero-extended, or sign-extended from bit 7 or 15 when i_req_signed=1.
- MISALIGN_TRAP=1 with a misaligned request: no memory or IO access, o_rsp_err=1, data 0. Path is ACC0 then RESP.
- Fault cases (o_rsp_err=1, no write, data 0):
  - any byte of a DMEM access lies at or above DMEM_WORDS*4; no wrap to word 0;
  - unmapped address;
  - store to the switch register;
  - IO access that is not a word-aligned word.
- IO map, word access only:
  - 0x1000_0000 LEDR.
  - 0x1000_1000 LEDG.
  - 0x1000_2000 HEX digits 0-3, 7 bits per byte lane.
  - 0x1000_3000 HEX digits 4-7.
  - 0x1000_4000 LCD.
  - 0x1001_0000 SW, read-only.
  - Output registers read back their current value.
  - Digits at index N_HEX or above are ignored on write and read as 0.
- i_io_sw passes through a 2-flop synchronizer. Loads return the synchronized value.
- DMEM contents are not reset. The DMEM is a single port with byte-enable write and synchronous read.

## Timing

- Reset values:
  - state IDLE;
  - o_req_ready 1;
  - o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0;
  - LEDR, LEDG and LCD 0; all HEX 0;
  - synchronizer 0.
- Reset mid-operation: return to IDLE immediately. A second-word write not yet committed is dropped. No response is issued.
- Take the handshake at edge E0.
  - ACC0 read/write commits at E1.
  - ACC1 commits at E2.
  - o_rsp_valid is high in the cycle after the last access edge.
- Latency:
  - aligned and trapped accesses: o_rsp_valid 2 cycles after E0;
  - split accesses: 3 cycles after E0.
- o_req_ready returns high the cycle after RESP. Back-to-back throughput is 1 request per 3 cycles aligned, 4 cycles split.
- An IO register updates at E1 and is visible on its output from E1.
- Store followed by load to the same address returns the new data, with no hazard, because accesses are serialized.
- Inputs are ignored outside IDLE.

## Test plan

- Aligned word: store 0xDEADBEEF at 0x100, then load word from 0x100. Expected: rsp 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- Split word: store 0x11223344 at 0x103.
  - Load byte signed at 0x103 returns 0x00000044.
  - Load byte signed at 0x106 returns 0x00000011.
  - Load word at 0x103 returns 0x11223344 at 3 cycles latency.
  - Word 0x100 byte 3 = 0x44; word 0x104 bytes 0-2 = 0x33, 0x22, 0x11, other bytes unchanged.
- Sign/size: store 0x0000_80FF word at 0x200.
  - lh signed at 0x200 returns 0xFFFF80FF.
  - lhu returns 0x000080FF.
  - lb signed at 0x201 returns 0xFFFFFF80.
- Trap mode, MISALIGN_TRAP=1: store word at 0x101. Expected: err 1, memory unchanged. Also a DMEM_WORDS*4-2 word access: err 1, no wrap write to word 0.
- IO:
  - Store 0x0000_007F to 0x1000_2000: digit 0 = 0x7F from E1.
  - Store to 0x1001_0000: err 1.
  - Set i_io_sw=0xA5, wait 2 cycles, load 0x1001_0000: returns 0xA5.
- Reset mid split store: assert i_reset during ACC1. Expected: FSM back to IDLE, ready 1, no rsp, second word unchanged, IO outputs 0.

Source files
------------

// File: rtl/lsu_mc.sv
// Multi-cycle handshaked load/store unit: synchronous-read DMEM plus memory-mapped IO.
// Misaligned accesses are split into two word accesses or trapped, per MISALIGN_TRAP.
module lsu_mc #(
   parameter int DMEM_WORDS    = 512,
   parameter int N_HEX         = 8,
   parameter int MISALIGN_TRAP = 0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [31:0]        i_req_addr,
   input  logic [31:0]        i_req_wdata,
   input  logic [1:0]         i_req_size,
   input  logic               i_req_wren,
   input  logic               i_req_signed,
   output logic               o_rsp_valid,
   output logic [31:0]        o_rsp_rdata,
   output logic               o_rsp_err,
   output logic [31:0]        o_io_ledr,
   output logic [31:0]        o_io_ledg,
   output logic [31:0]        o_io_lcd,
   output logic [N_HEX*7-1:0] o_io_hex,
   input  logic [31:0]        i_io_sw
);
   localparam int AW = $clog2(DMEM_WORDS);
   localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t state_q, state_d;

   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic        wren_q, sgn_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         wren_q  <= 1'b0;
         sgn_q   <= 1'b0;
      end else if (state_q == IDLE && i_req_valid) begin
         addr_q  <= i_req_addr;
         wdata_q <= i_req_wdata;
         size_q  <= i_req_size;
         wren_q  <= i_req_wren;
         sgn_q   <= i_req_signed;
      end
   end

   // Request decode works on the latched request, so it is stable from ACC0 through RESP
   logic [1:0]  off;
   logic        is_half, is_word, misal, split, dmem_hit, io_hit, err, dmem_go, io_go;
   logic        sel_ledr, sel_ledg, sel_hex0, sel_hex1, sel_lcd, sel_sw;
   logic [32:0] last;

   always_comb begin
      off      = addr_q[1:0];
      is_half  = (size_q == 2'b01);
      is_word  = size_q[1];
      misal    = (is_half & off[0]) | (is_word & (off != 2'b00));
      split    = (is_word & (off != 2'b00)) | (is_half & (off == 2'b11));
      last     = {1'b0, addr_q} + (is_word ? 33'd3 : is_half ? 33'd1 : 33'd0);
      dmem_hit = (last < DMEM_BYTES);
      sel_ledr = (addr_q == 32'h1000_0000);
      sel_ledg = (addr_q == 32'h1000_1000);
      sel_hex0 = (addr_q == 32'h1000_2000);
      sel_hex1 = (addr_q == 32'h1000_3000);
      sel_lcd  = (addr_q == 32'h1000_4000);
      sel_sw   = (addr_q == 32'h1001_0000);
      io_hit   = is_word & (off == 2'b00) & !(sel_sw & wren_q) &
                 (sel_ledr | sel_ledg | sel_hex0 | sel_hex1 | sel_lcd | sel_sw);
      err      = ((MISALIGN_TRAP != 0) & misal) | !(dmem_hit | io_hit);
      dmem_go  = !err & dmem_hit;
      io_go    = !err & io_hit;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_req_valid) state_d = ACC0;
         ACC0:    state_d = (dmem_go & split) ? ACC1 : RESP;
         ACC1:    state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Data memory: byte-enable write, registered read
   logic [31:0] mem [DMEM_WORDS];
   logic [31:0] mem_q, w0_q, mem_wd;
   logic [AW-1:0] mem_idx;
   logic [3:0]  mem_be;
   logic        mem_en;
   logic [7:0]  be64;
   logic [63:0] wd64;

   always_comb begin
      be64    = {4'b0000, (is_word ? 4'hF : is_half ? 4'h3 : 4'h1)} << off;
      wd64    = {32'b0, wdata_q} << {off, 3'b000};
      mem_en  = (state_q == ACC0 && dmem_go) || (state_q == ACC1);
      mem_idx = (state_q == ACC1) ? addr_q[AW+1:2] + 1'b1 : addr_q[AW+1:2];
      mem_be  = !wren_q ? 4'h0 : (state_q == ACC1) ? be64[7:4] : be64[3:0];
      mem_wd  = (state_q == ACC1) ? wd64[63:32] : wd64[31:0];
   end

   always_ff @(posedge i_clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
         mem_q <= mem[mem_idx];
      end
      if (state_q == ACC1) w0_q <= mem_q;
   end

   // IO registers and switch synchronizer
   logic [31:0] ledr_q, ledg_q, lcd_q, sw_meta, sw_sync, io_q, io_rd;
   logic [55:0] hex_q;
   logic [63:0] hex_rd;

   always_comb begin
      hex_rd = '0;
      for (int i = 0; i < 8; i++) hex_rd[8*i +: 8] = {1'b0, hex_q[7*i +: 7]};
      io_rd = ({32{sel_ledr}} & ledr_q) | ({32{sel_ledg}} & ledg_q) |
              ({32{sel_hex0}} & hex_rd[31:0]) | ({32{sel_hex1}} & hex_rd[63:32]) |
              ({32{sel_lcd}} & lcd_q) | ({32{sel_sw}} & sw_sync);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ledr_q  <= '0;
         ledg_q  <= '0;
         lcd_q   <= '0;
         hex_q   <= '0;
         io_q    <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= i_io_sw;
         sw_sync <= sw_meta;
         if (state_q == ACC0 && io_go) begin
            io_q <= io_rd;
            if (wren_q) begin
               if (sel_ledr) ledr_q <= wdata_q;
               if (sel_ledg) ledg_q <= wdata_q;
               if (sel_lcd)  lcd_q  <= wdata_q;
               for (int i = 0; i < N_HEX; i++)
                  if (i < 4 ? sel_hex0 : sel_hex1) hex_q[7*i +: 7] <= wdata_q[8*(i%4) +: 7];
            end
         end
      end
   end

   // Response: align {word1, word0} down by the byte offset, then size/extend
   logic [63:0] rd64;
   logic [31:0] ld, ldx;

   always_comb begin
      rd64 = io_go ? {32'b0, io_q} : split ? {mem_q, w0_q} : {32'b0, mem_q};
      ld   = 32'(rd64 >> {off, 3'b000});
      if (is_word)      ldx = ld;
      else if (is_half) ldx = {{16{sgn_q & ld[15]}}, ld[15:0]};
      else              ldx = {{24{sgn_q & ld[7]}}, ld[7:0]};
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_rsp_valid = (state_q == RESP);
   assign o_rsp_err   = (state_q == RESP) & err;
   assign o_rsp_rdata = (state_q == RESP && !err && !wren_q) ? ldx : 32'h0;
   assign o_io_ledr   = ledr_q;
   assign o_io_ledg   = ledg_q;
   assign o_io_lcd    = lcd_q;
   assign o_io_hex    = hex_q[N_HEX*7-1:0];
endmodule
